// File: rtl/xbar_ctrl_lock.sv
// xbar_ctrl_lock
// Registered crossbar controller with wormhole connection locking.
// Turns per-input one-hot allocation rows into binary selects for the
// output muxes (out_sel) and the input demuxes (in_sel), one cycle after
// the request is sampled. While lock_en is high, a granted non-tail flit
// locks its input to its output until the tail flit. Dropped requests set a
// sticky flag and are tallied in a saturating counter.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   alloc_vec    row i at [i*NUM_PORT +: NUM_PORT]: output(s) granted to input i
//   alloc_valid  bit i qualifies row i
//   tail         bit i: input i's flit this cycle is a tail
//   lock_en      1 = wormhole hold mode, 0 = per-cycle mode
//   out_sel      field j: input index driving output j
//   out_vld      output j connected
//   in_sel       field i: output index fed by input i
//   in_vld       input i connected
//   conflict     sticky: a request has been dropped since reset
//   conflict_cnt saturating count of dropped requests
module xbar_ctrl_lock #(
  parameter int unsigned NUM_PORT     = 5,
  parameter int unsigned LOG_NUM_PORT = 3,
  parameter int unsigned CNT_W        = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_PORT*NUM_PORT-1:0]     alloc_vec,
  input  logic [NUM_PORT-1:0]              alloc_valid,
  input  logic [NUM_PORT-1:0]              tail,
  input  logic                             lock_en,
  output logic [NUM_PORT*LOG_NUM_PORT-1:0] out_sel,
  output logic [NUM_PORT-1:0]              out_vld,
  output logic [NUM_PORT*LOG_NUM_PORT-1:0] in_sel,
  output logic [NUM_PORT-1:0]              in_vld,
  output logic                             conflict,
  output logic [CNT_W-1:0]                 conflict_cnt
);

  typedef enum logic {IDLE, LOCKED} lock_state_e;
  typedef logic [LOG_NUM_PORT-1:0] sel_t;
  typedef logic [NUM_PORT-1:0]     row_t;

  // Wide enough to hold the counter plus up to NUM_PORT drops in one cycle.
  localparam int unsigned SUM_W = CNT_W + LOG_NUM_PORT + 1;

  lock_state_e state_q    [NUM_PORT];
  lock_state_e state_d    [NUM_PORT];
  sel_t        lock_out_q [NUM_PORT];
  sel_t        lock_out_d [NUM_PORT];

  logic [NUM_PORT*LOG_NUM_PORT-1:0] out_sel_q, out_sel_d;
  logic [NUM_PORT*LOG_NUM_PORT-1:0] in_sel_q, in_sel_d;
  logic [NUM_PORT-1:0]              out_vld_q, out_vld_d;
  logic [NUM_PORT-1:0]              in_vld_q, in_vld_d;
  logic                             conflict_q, conflict_d;
  logic [CNT_W-1:0]                 cnt_q, cnt_d;

  row_t       row      [NUM_PORT];
  sel_t       req_out  [NUM_PORT];
  sel_t       conn_out [NUM_PORT];
  logic [NUM_PORT-1:0] held, active, multi, granted, drop, conn, out_busy;
  logic [SUM_W-1:0]    cnt_sum;

  // Request decode: a locked input (with lock_en still high) ignores its row.
  always_comb begin
    for (int unsigned i = 0; i < NUM_PORT; i++) begin
      row[i]     = alloc_vec[i*NUM_PORT +: NUM_PORT];
      held[i]    = (state_q[i] == LOCKED) && lock_en;
      active[i]  = !held[i] && alloc_valid[i] && (|row[i]);
      multi[i]   = active[i] && (|(row[i] & (row[i] - row_t'(1))));
      req_out[i] = '0;
      // Scan high to low so the lowest set bit wins.
      for (int unsigned j = NUM_PORT; j > 0; j--) begin
        if (row[i][j-1]) req_out[i] = sel_t'(j - 1);
      end
    end
  end

  // Arbitration, lock next-state and registered-output next values.
  always_comb begin
    out_busy   = '0;
    granted    = '0;
    drop       = '0;
    conn       = '0;
    out_sel_d  = '0;
    out_vld_d  = '0;
    in_sel_d   = '0;
    in_vld_d   = '0;
    for (int unsigned i = 0; i < NUM_PORT; i++) begin
      state_d[i]    = IDLE;
      lock_out_d[i] = lock_out_q[i];
      conn_out[i]   = '0;
    end

    for (int unsigned i = 0; i < NUM_PORT; i++) begin
      for (int unsigned j = 0; j < NUM_PORT; j++) begin
        if (held[i] && (lock_out_q[i] == sel_t'(j))) out_busy[j] = 1'b1;
      end
    end

    for (int unsigned i = 0; i < NUM_PORT; i++) begin
      granted[i] = active[i];
      for (int unsigned j = 0; j < NUM_PORT; j++) begin
        if (out_busy[j] && (req_out[i] == sel_t'(j))) granted[i] = 1'b0;
      end
      for (int unsigned k = 0; k < NUM_PORT; k++) begin
        if ((k < i) && active[k] && (req_out[k] == req_out[i])) granted[i] = 1'b0;
      end
      // A multi-hot row is one conflict even when its lowest bit is granted;
      // an input contributes at most one count per cycle.
      drop[i] = active[i] && (!granted[i] || multi[i]);

      if (held[i]) begin
        // Tail cycle keeps the connection; the lock is gone after this edge.
        conn[i]     = 1'b1;
        conn_out[i] = lock_out_q[i];
        if (!tail[i]) state_d[i] = LOCKED;
      end else if (granted[i]) begin
        conn[i]     = 1'b1;
        conn_out[i] = req_out[i];
        if (lock_en && !tail[i]) begin
          state_d[i]    = LOCKED;
          lock_out_d[i] = req_out[i];
        end
      end
    end

    for (int unsigned i = 0; i < NUM_PORT; i++) begin
      in_vld_d[i] = conn[i];
      if (conn[i]) in_sel_d[i*LOG_NUM_PORT +: LOG_NUM_PORT] = conn_out[i];
      for (int unsigned j = 0; j < NUM_PORT; j++) begin
        if (conn[i] && (conn_out[i] == sel_t'(j))) begin
          out_vld_d[j] = 1'b1;
          out_sel_d[j*LOG_NUM_PORT +: LOG_NUM_PORT] = sel_t'(i);
        end
      end
    end

    cnt_sum = SUM_W'(cnt_q);
    for (int unsigned i = 0; i < NUM_PORT; i++) begin
      cnt_sum = cnt_sum + SUM_W'(drop[i]);
    end
    cnt_d      = (|cnt_sum[SUM_W-1:CNT_W]) ? '1 : cnt_sum[CNT_W-1:0];
    conflict_d = conflict_q | (|drop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_PORT; i++) begin
        state_q[i]    <= IDLE;
        lock_out_q[i] <= '0;
      end
      out_sel_q  <= '0;
      out_vld_q  <= '0;
      in_sel_q   <= '0;
      in_vld_q   <= '0;
      conflict_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_PORT; i++) begin
        state_q[i]    <= state_d[i];
        lock_out_q[i] <= lock_out_d[i];
      end
      out_sel_q  <= out_sel_d;
      out_vld_q  <= out_vld_d;
      in_sel_q   <= in_sel_d;
      in_vld_q   <= in_vld_d;
      conflict_q <= conflict_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_sel      = out_sel_q;
  assign out_vld      = out_vld_q;
  assign in_sel       = in_sel_q;
  assign in_vld       = in_vld_q;
  assign conflict     = conflict_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_xbar_ctrl_lock.sv
// Bench for xbar_ctrl_lock: directed test-plan steps followed by random
// traffic, all compared against a behavioural reference model. A second
// instance with a 2-bit counter shares the stimulus to exercise saturation.
module tb_xbar_ctrl_lock;

  localparam int N = 5;
  localparam int L = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic [N*N-1:0]   alloc_vec;
  logic [N-1:0]     alloc_valid;
  logic [N-1:0]     tail;
  logic             lock_en;

  logic [N*L-1:0]   out_sel, in_sel, out_sel_s, in_sel_s;
  logic [N-1:0]     out_vld, in_vld, out_vld_s, in_vld_s;
  logic             conflict, conflict_s;
  logic [7:0]       conflict_cnt;
  logic [1:0]       conflict_cnt_s;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  xbar_ctrl_lock #(.NUM_PORT(N), .LOG_NUM_PORT(L), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .alloc_vec(alloc_vec), .alloc_valid(alloc_valid),
    .tail(tail), .lock_en(lock_en), .out_sel(out_sel), .out_vld(out_vld),
    .in_sel(in_sel), .in_vld(in_vld), .conflict(conflict), .conflict_cnt(conflict_cnt)
  );

  xbar_ctrl_lock #(.NUM_PORT(N), .LOG_NUM_PORT(L), .CNT_W(2)) dut_s (
    .clk(clk), .reset(reset), .alloc_vec(alloc_vec), .alloc_valid(alloc_valid),
    .tail(tail), .lock_en(lock_en), .out_sel(out_sel_s), .out_vld(out_vld_s),
    .in_sel(in_sel_s), .in_vld(in_vld_s), .conflict(conflict_s), .conflict_cnt(conflict_cnt_s)
  );

  // Reference model: which outputs each input holds, plus expected outputs.
  bit             m_lock [N];
  int             m_dst  [N];
  int             m_cnt;
  bit             m_conf;
  logic [N*L-1:0] e_out_sel, e_in_sel;
  logic [N-1:0]   e_out_vld, e_in_vld;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_lock[i] = 1'b0;
      m_dst[i]  = 0;
    end
    m_cnt = 0; m_conf = 1'b0;
    e_out_sel = '0; e_in_sel = '0; e_out_vld = '0; e_in_vld = '0;
  endtask

  // One clock edge: outputs are claimed by holders first, then by requesting
  // inputs in ascending index order; anything left over is a drop.
  task automatic model_step();
    int owner [N];
    int tgt   [N];
    bit held  [N];
    bit act   [N];
    bit multi [N];
    bit gnt   [N];
    int drops;
    logic [N-1:0] r;
    drops = 0;
    for (int j = 0; j < N; j++) owner[j] = -1;
    for (int i = 0; i < N; i++) begin
      held[i] = m_lock[i] && lock_en;
      if (held[i]) owner[m_dst[i]] = i;
    end
    for (int i = 0; i < N; i++) begin
      r = alloc_vec[i*N +: N];
      act[i]   = !held[i] && alloc_valid[i] && (r != 0);
      multi[i] = $countones(r) > 1;
      tgt[i]   = 0;
      for (int b = N - 1; b >= 0; b--) if (r[b]) tgt[i] = b;
    end
    for (int i = 0; i < N; i++) begin
      gnt[i] = 1'b0;
      if (act[i]) begin
        if (owner[tgt[i]] < 0) begin
          owner[tgt[i]] = i;
          gnt[i] = 1'b1;
        end
        if (!gnt[i] || multi[i]) drops++;
      end
    end
    e_out_sel = '0; e_in_sel = '0; e_out_vld = '0; e_in_vld = '0;
    for (int j = 0; j < N; j++) begin
      if (owner[j] >= 0) begin
        e_out_vld[j] = 1'b1;
        e_out_sel[j*L +: L] = L'(owner[j]);
        e_in_vld[owner[j]] = 1'b1;
        e_in_sel[owner[j]*L +: L] = L'(j);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (held[i] && !tail[i]) begin
        m_lock[i] = 1'b1;
      end else if (gnt[i] && lock_en && !tail[i]) begin
        m_lock[i] = 1'b1;
        m_dst[i]  = tgt[i];
      end else begin
        m_lock[i] = 1'b0;
      end
    end
    m_cnt  = m_cnt + drops;
    m_conf = m_conf | (drops > 0);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".out_sel"}, 64'(out_sel), 64'(e_out_sel));
    chk({tag, ".out_vld"}, 64'(out_vld), 64'(e_out_vld));
    chk({tag, ".in_sel"},  64'(in_sel),  64'(e_in_sel));
    chk({tag, ".in_vld"},  64'(in_vld),  64'(e_in_vld));
    chk({tag, ".conflict"}, 64'(conflict), 64'(m_conf));
    chk({tag, ".cnt"}, 64'(conflict_cnt), 64'((m_cnt > 255) ? 255 : m_cnt));
    chk({tag, ".s_out_sel"}, 64'(out_sel_s), 64'(e_out_sel));
    chk({tag, ".s_in_sel"},  64'(in_sel_s),  64'(e_in_sel));
    chk({tag, ".s_cnt"}, 64'(conflict_cnt_s), 64'((m_cnt > 3) ? 3 : m_cnt));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    #1;
    model_step();
    check_all(tag);
  endtask

  task automatic drive(input logic [N*N-1:0] v, input logic [N-1:0] val,
                       input logic [N-1:0] tl, input logic le);
    alloc_vec = v; alloc_valid = val; tail = tl; lock_en = le;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic [N*N-1:0] v;
  logic [N*L-1:0] sel_tmp;

  initial begin
    reset = 1'b1;
    drive('0, '0, '0, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    reset = 1'b0;

    // Diagonal, per-cycle mode: input i -> output 4-i.
    v = '0;
    for (int i = 0; i < N; i++) v[i*N + (N - 1 - i)] = 1'b1;
    drive(v, '1, '0, 1'b0);
    step("diag");
    chk("diag.sel_const", 64'(out_sel), 64'({3'd0, 3'd1, 3'd2, 3'd3, 3'd4}));
    chk("diag.vld_const", 64'(out_vld & in_vld), 64'(5'b11111));

    // Five cyclic shifts on consecutive cycles.
    for (int r = 0; r < N; r++) begin
      v = '0;
      for (int i = 0; i < N; i++) v[i*N + ((N - 1 - i + r) % N)] = 1'b1;
      drive(v, '1, '0, 1'b0);
      step("rot");
      sel_tmp = in_sel;
      chk("rot.in_sel0", 64'(sel_tmp[0 +: L]), 64'((N - 1 + r) % N));
    end

    // Lock: input 1 -> output 3, then input 2 contends for three cycles.
    do_reset();
    v = '0; v[1*N + 3] = 1'b1;
    drive(v, 5'b00010, '0, 1'b1);
    step("lock.head");
    v = '0; v[2*N + 3] = 1'b1;
    drive(v, 5'b00100, '0, 1'b1);
    for (int c = 0; c < 3; c++) step("lock.hold");
    sel_tmp = out_sel;
    chk("lock.out3", 64'(sel_tmp[3*L +: L]), 64'(1));
    chk("lock.cnt3", 64'(conflict_cnt), 64'(3));
    drive(v, 5'b00100, 5'b00010, 1'b1);
    step("lock.tail");
    drive(v, 5'b00100, '0, 1'b1);
    step("lock.after");
    sel_tmp = out_sel;
    chk("lock.out3_new", 64'(sel_tmp[3*L +: L]), 64'(2));

    // Same-cycle contention plus multi-hot row; repeated to saturate dut_s.
    do_reset();
    v = '0;
    v[0*N + 2] = 1'b1;
    v[4*N + 2] = 1'b1;
    v[3*N + 1] = 1'b1; v[3*N + 2] = 1'b1;
    drive(v, 5'b11001, '0, 1'b0);
    step("cont");
    sel_tmp = out_sel;
    chk("cont.out2", 64'(sel_tmp[2*L +: L]), 64'(0));
    chk("cont.out1", 64'(sel_tmp[1*L +: L]), 64'(3));
    chk("cont.in_vld4", 64'(in_vld[4]), 64'(0));
    chk("cont.conflict", 64'(conflict), 64'(1));
    chk("cont.cnt", 64'(conflict_cnt), 64'(2));
    step("sat");
    step("sat");
    chk("sat.cnt_s", 64'(conflict_cnt_s), 64'(3));
    chk("sat.cnt", 64'(conflict_cnt), 64'(6));

    // Asynchronous reset in the middle of a locked packet.
    do_reset();
    v = '0; v[0*N + 1] = 1'b1;
    drive(v, 5'b00001, '0, 1'b1);
    step("mid.lock");
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("mid.async");
    chk("mid.async_vld", 64'(out_vld | in_vld), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    v = '0; v[3*N + 1] = 1'b1;
    drive(v, 5'b01000, '0, 1'b1);
    step("mid.post");
    sel_tmp = out_sel;
    chk("mid.post_out1", 64'(sel_tmp[1*L +: L]), 64'(3));

    // Random traffic against the model.
    for (int c = 0; c < 300; c++) begin
      v = '0;
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(0, 9))
          0, 1:    v[i*N +: N] = 5'($urandom);
          2:       v[i*N +: N] = '0;
          default: v[i*N + $urandom_range(0, N - 1)] = 1'b1;
        endcase
      end
      drive(v, 5'($urandom), 5'($urandom & $urandom),
            ($urandom_range(0, 9) != 0));
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/xbar_ctrl_lock.md
Name: xbar_ctrl_lock

Overview:
- Registered, parametrised successor to the combinational crossbar controller.
- Converts per-input one-hot allocation rows into binary crossbar selects for both output muxes and input demuxes.
- Adds wormhole connection locking held until tail flit, conflict resolution, and sticky error/statistics.
- Sits between the switch allocator and the crossbar datapath in each router.

Parameters:
NUM_PORT, 5, number of router ports (4-LOCAL, 3-N, 2-S, 1-E, 0-W for default)
LOG_NUM_PORT, 3, select width, >= clog2(NUM_PORT)
CNT_W, 8, width of saturating conflict counter

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
alloc_vec  input  NUM_PORT*NUM_PORT  row i at [i*NUM_PORT+:NUM_PORT]: output(s) granted to input i
alloc_valid  input  NUM_PORT  bit i qualifies row i
tail  input  NUM_PORT  bit i: input i's flit this cycle is a tail
lock_en  input  1  1 = wormhole hold mode, 0 = per-cycle mode
out_sel  output  NUM_PORT*LOG_NUM_PORT  field j: input index driving output j
out_vld  output  NUM_PORT  output j connected
in_sel  output  NUM_PORT*LOG_NUM_PORT  field i: output index fed by input i
in_vld  output  NUM_PORT  input i connected
conflict  output  1  sticky: any request dropped since reset
conflict_cnt  output  CNT_W  saturating count of dropped requests

Behaviour:
- Reset (async, immediate): all out_sel/in_sel = 0, out_vld/in_vld = 0, conflict = 0, conflict_cnt = 0, all locks cleared.
- Latency: one cycle; request sampled at edge k drives outputs after edge k.
- Request of input i is active when alloc_valid[i]=1 and row i nonzero. Multi-hot row: lowest set bit used, counted as one conflict.
- Per input state, 2 states:
  - IDLE: active request to output j is granted if output j is free and input i is lowest-index active requester of j; otherwise dropped (conflict).
  - LOCKED(j): entered on grant when lock_en=1 and tail[i]=0.
  - LOCKED(j) holds connection regardless of alloc_vec/alloc_valid; new requests from input i are ignored and not counted.
  - LOCKED -> IDLE on edge where tail[i]=1; connection remains valid during that tail cycle, free next cycle.
- Output j is free when no input is LOCKED(j). Requests from other inputs to a locked output are dropped and counted.
- Grant with tail[i]=1 in IDLE, or any grant with lock_en=0: connection valid one cycle only (single-flit), no lock.
- lock_en=0 sampled at an edge releases all locks at that edge; only current-cycle grants drive outputs.
- Registered outputs each cycle:
  - out_vld[j]=1 and out_sel[j]=i for granted or locked input i.
  - in_vld[i]=1 and in_sel[i]=j symmetrically.
  - Unconnected fields: sel=0, vld=0.
  - Invariant: no two out_vld fields share an input; mapping is a partial permutation.
- conflict_cnt: +1 per dropped request per cycle; several drops in one cycle add their total; saturates at 2^CNT_W-1, no wrap. conflict sets on first drop, clears only on reset.
- Reset mid-packet: locks dropped immediately; first post-reset grant follows IDLE rules.

Test Plan:
- Diagonal, lock_en=0, all valid: rows 10000,01000,00100,00010,00001 -> next cycle out_sel[4]=0, out_sel[3]=1, out_sel[2]=2, out_sel[1]=3, out_sel[0]=4; all vld=1; conflict=0.
- Rotations: apply the five cyclic shifts of the diagonal on consecutive cycles -> each cycle out_sel/in_sel are exact inverses; in_sel[i] matches bit index of row i one cycle later.
- Lock:
  - lock_en=1, input 1 -> output 3, tail=0; then input 2 requests output 3 for 3 cycles -> out_sel[3]=1 held.
  - conflict_cnt=3.
  - tail[1]=1 -> output 3 released; next input 2 request granted.
- Same-cycle contention: inputs 0 and 4 both request output 2 -> out_sel[2]=0, in_vld[4]=0, conflict=1, conflict_cnt+1; multi-hot row 00110 on input 3 -> output 1 granted, +1 count.
- Saturation/reset: CNT_W=2, force 5 drops -> conflict_cnt=3. Assert reset mid-lock asynchronously -> all outputs 0 before next edge; post-reset request granted normally.
